// File: rtl/div_unit_pkg.sv
// Shared widths, state encodings and stall bus sizing for the divider.
package div_unit_pkg;

  localparam int StallBus = 6;
  localparam int DataW    = 32;
  localparam int ResW     = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Signed DIV support is built only when DIV_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_div_i,
  input  logic [DataW-1:0] opdata1_i,
  input  logic [DataW-1:0] opdata2_i,
  input  logic            annul_i,
  output logic [ResW-1:0]  result_o,
  output logic            ready_o,
  output logic            stallreq_for_ex
);

  div_state_e state, state_nxt;

  logic [4:0]         cnt;
  logic [2*DataW:0]   rem;
  logic [2*DataW:0]   rem_sh;
  logic [2*DataW:0]   rem_nxt;
  logic [DataW+1:0]   trial;
  logic [DataW-1:0]   dvs;
  logic [DataW-1:0]   mag1;
  logic [DataW-1:0]   mag2;
  logic [DataW-1:0]   quo;
  logic [DataW-1:0]   rmd;
  logic               req;
  logic               unused_bits;

  assign req = start_i && !annul_i;

  assign stallreq_for_ex = rst && req && (state != DivEnd);

  // Top remainder bit is always zero after a step; only the low 64 shift on.
  assign rem_sh  = {rem[2*DataW-1:0], 1'b0};
  assign trial   = {1'b0, rem_sh[2*DataW:DataW]} - {2'b00, dvs};
  assign rem_nxt = trial[DataW+1] ? rem_sh
                 : {trial[DataW:0], rem_sh[DataW-1:1], 1'b1};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign mag1 = (signed_div_i && opdata1_i[DataW-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DataW-1]) ? -opdata2_i : opdata2_i;
  assign quo  = neg_q ? -rem_nxt[DataW-1:0] : rem_nxt[DataW-1:0];
  assign rmd  = neg_r ? -rem_nxt[2*DataW-1:DataW]
                      : rem_nxt[2*DataW-1:DataW];
  assign unused_bits = rem[2*DataW];
`else
  assign mag1 = opdata1_i;
  assign mag2 = opdata2_i;
  assign quo  = rem_nxt[DataW-1:0];
  assign rmd  = rem_nxt[2*DataW-1:DataW];
  assign unused_bits = rem[2*DataW] ^ signed_div_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DivFree;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DivFree: begin
        if (req) begin
          state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: state_nxt = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)           state_nxt = DivFree;
        else if (cnt == 5'd31) state_nxt = DivEnd;
      end
      DivEnd: begin
        if (!start_i) state_nxt = DivFree;
      end
      default: state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      ready_o <= 1'b0;
      case (state)
        DivFree: begin
          if (req && opdata2_i != '0) begin
            rem <= {{(DataW+1){1'b0}}, mag1};
            dvs <= mag2;
            cnt <= '0;
`ifdef DIV_SIGNED_EN
            neg_q <= signed_div_i && (opdata1_i[DataW-1] ^ opdata2_i[DataW-1]);
            neg_r <= signed_div_i && opdata1_i[DataW-1];
`endif
          end
        end
        DivByZero: begin
          if (!annul_i) result_o <= '0;
        end
        DivOn: begin
          if (!annul_i) begin
            rem <= rem_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) result_o <= {rmd, quo};
          end
        end
        DivEnd: ready_o <= start_i;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: EX requests a divide; held high until ready_o is seen.
REQ-004 SHALL have port signed_div_i, input, 1 bit: 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port opdata1_i, input, 32 bits: dividend; sampled only at acceptance.
REQ-006 SHALL have port opdata2_i, input, 32 bits: divisor; sampled only at acceptance.
REQ-007 SHALL have port annul_i, input, 1 bit: cancel the current divide (pipeline flush).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, registered.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-010 SHALL have port stallreq_for_ex, output, 1 bit: stall request to the stall controller.

Function
REQ-011 SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i=0: SHALL go to BYZERO.
REQ-013 FREE, start_i=1, annul_i=0, opdata2_i!=0: SHALL latch operand magnitudes, clear the 5-bit counter, and go to ON.
REQ-014 BYZERO: SHALL load result_o=64'h0 and go to END next cycle.
REQ-015 ON: SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial remainder and increment the counter.
REQ-016 ON: after the 32nd step SHALL apply sign fix-up, load result_o, and go to END.
REQ-017 Latency: ready_o SHALL rise exactly 33 cycles after the start_i acceptance edge (2 cycles for divide-by-zero).
REQ-018 END: SHALL hold ready_o=1 and result_o stable while start_i=1, and return to FREE with ready_o=0 when start_i=0.
REQ-019 annul_i=1 in ON or BYZERO SHALL return the unit to FREE next cycle, with ready_o never asserted and result_o unchanged.
REQ-020 annul_i=1 in FREE SHALL prevent acceptance.
REQ-021 annul_i SHALL have priority over start_i.
REQ-022 stallreq_for_ex SHALL equal start_i AND NOT annul_i AND (state != END), combinationally, so EX stalls in the request cycle itself.
REQ-023 Signed mode: quotient SHALL be negative iff operand signs differ; remainder SHALL take the dividend's sign.
REQ-024 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
REQ-025 Operands changing after acceptance SHALL have no effect on the result.

Reset
REQ-026 rst low SHALL immediately force state=FREE, counter=0, result_o=0, ready_o=0, and the partial remainder to 0, independent of clk, including mid-divide.
REQ-027 stallreq_for_ex SHALL be 0 while rst is low.
REQ-028 Operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-029 Macro DIV_SIGNED_EN defined: signed_div_i SHALL be honoured (REQ-023/024).
REQ-030 Macro DIV_SIGNED_EN undefined: signed_div_i SHALL be ignored; all divides SHALL be unsigned, and no negation/fix-up logic SHALL be synthesised.

Structure
REQ-031 State encodings (DivFree, DivByZero, DivOn, DivEnd) SHALL live in the shared defines header alongside StallBus.
REQ-032 Result width 64 and operand width 32 SHALL live in the shared defines header alongside StallBus.
REQ-033 SHALL be a single module with no sub-modules; the datapath is small enough to keep inline.

Verification
REQ-034 Unsigned 100/7, start held -> stallreq_for_ex=1 for 33 cycles; ready_o at cycle 33; result_o={32'd2,32'd14}.
REQ-035 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; without DIV_SIGNED_EN -> quotient 0x7FFFFFFC, remainder 0x1.
REQ-036 Divisor 0 -> ready_o at cycle 2; result_o=0; stallreq_for_ex low from cycle 2.
REQ-037 annul_i pulsed at ON cycle 10 -> FREE next cycle; ready_o never asserts; a new 50/5 request then gives quotient 10, remainder 0.
REQ-038 rst low at ON cycle 20 -> all outputs 0 immediately; a fresh 0x80000000/0xFFFFFFFF signed divide afterwards -> quotient 0x80000000, remainder 0.
REQ-039 start_i held in END for 5 cycles -> ready_o and result_o stable throughout; start_i dropped -> ready_o=0 next cycle.
